// File: rtl/adder_arb.sv
// Round-robin arbiter in front of one shared W-bit adder.
// A granted requester's operands are captured, summed, then held until the consumer accepts.
module adder_arb #(
  parameter int W = 4,
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [W:0]     y_out,
  output logic [IW-1:0]  y_id,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [7:0]     op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  a_lat_q, a_lat_d;
  logic [W-1:0]  b_lat_q, b_lat_d;
  logic [IW-1:0] id_lat_q, id_lat_d;
  logic [W:0]    y_out_q, y_out_d;
  logic [IW-1:0] y_id_q, y_id_d;
  logic          y_valid_q, y_valid_d;
  logic [7:0]    op_count_q, op_count_d;

  logic          found_s;
  logic [IW-1:0] win_s;
  logic [W:0]    sum_s;

  // Round-robin pick: scan downward from ptr+N-1 to ptr so the last hit is the first set bit at/after ptr.
  always_comb begin
    found_s = |req;
    win_s   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      win_s = req[(int'(ptr_q) + k) % N] ? IW'((int'(ptr_q) + k) % N) : win_s;
    end
  end

  // The one shared adder; carry lands in the MSB.
  always_comb begin
    sum_s = {1'b0, a_lat_q} + {1'b0, b_lat_q};
  end

  // Grant is combinational and only offered in IDLE outside reset.
  always_comb begin
    if (!rst && (state_q == S_IDLE) && found_s) begin
      gnt = N'(1) << win_s;
    end else begin
      gnt = '0;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_lat_d    = a_lat_q;
    b_lat_d    = b_lat_q;
    id_lat_d   = id_lat_q;
    y_out_d    = y_out_q;
    y_id_d     = y_id_q;
    y_valid_d  = y_valid_q;
    op_count_d = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          a_lat_d  = a_in[int'(win_s)*W +: W];
          b_lat_d  = b_in[int'(win_s)*W +: W];
          id_lat_d = win_s;
          ptr_d    = (int'(win_s) == N - 1) ? '0 : win_s + IW'(1);
          state_d  = S_ADD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ADD: begin
        y_out_d   = sum_s;
        y_id_d    = id_lat_q;
        y_valid_d = 1'b1;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (y_valid_q && y_ready) begin
          y_valid_d  = 1'b0;
          op_count_d = op_count_q + 8'd1;
          state_d    = S_IDLE;
        end else begin
          state_d    = S_HOLD;
        end
      end
      default: begin
        y_valid_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      a_lat_q    <= '0;
      b_lat_q    <= '0;
      id_lat_q   <= '0;
      y_out_q    <= '0;
      y_id_q     <= '0;
      y_valid_q  <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_lat_q    <= a_lat_d;
      b_lat_q    <= b_lat_d;
      id_lat_q   <= id_lat_d;
      y_out_q    <= y_out_d;
      y_id_q     <= y_id_d;
      y_valid_q  <= y_valid_d;
      op_count_q <= op_count_d;
    end
  end

  assign y_out    = y_out_q;
  assign y_id     = y_id_q;
  assign y_valid  = y_valid_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_adder_arb.sv
// Scoreboard bench for adder_arb: stimulus pushes expected {id, sum}, a monitor pops on each accepted result.
module tb_adder_arb;
  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = 4'b1111;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic           y_ready = 1'b0;
  logic [N-1:0]   gnt;
  logic [W:0]     y_out;
  logic [1:0]     y_id;
  logic           y_valid;
  logic [7:0]     op_count;

  int         checks = 0;
  int         errors = 0;
  int         exp_q[$];
  logic [7:0] exp_count = 8'd0;
  int         cyc = 0;
  int         last_acc = -100;

  adder_arb #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .y_out(y_out), .y_id(y_id), .y_valid(y_valid),
    .y_ready(y_ready), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[id*W +: W] = a;
    b_in[id*W +: W] = b;
  endtask

  task automatic wait_gnt(input string name, input logic [N-1:0] exp_g);
    int n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, gnt, exp_g);
  endtask

  task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int exp_sum, input string name);
    @(posedge clk); #1;
    set_ops(id, a, b);
    req = N'(1) << id;
    wait_gnt(name, N'(1) << id);
    exp_q.push_back(id * 256 + exp_sum);
    @(posedge clk); #1;
    req  = '0;
    a_in = (N*W)'($urandom);
    b_in = (N*W)'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: checks the accept counter every cycle and scores each accepted result.
  always @(negedge clk) begin
    int e;
    cyc++;
    chk("op_count", op_count, exp_count);
    if (rst) begin
      exp_count = 8'd0;
      exp_q.delete();
    end else if (y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id %0d sum %0d expected none", y_id, y_out);
      end else begin
        e = exp_q.pop_front();
        chk("y_id", y_id, e / 256);
        chk("y_out", y_out, e % 256);
      end
      chk("acc_gap_ge3", (cyc - last_acc) >= 3, 1);
      last_acc = cyc;
      exp_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int sums  [4] = '{3, 13, 23, 30};
    logic [W-1:0] ra, rb;
    int rid;

    // reset state, requests held high must not be granted
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", y_valid, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_y_id", y_id, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;

    // first transaction: 3+5 from requester 0
    set_ops(0, 4'd3, 4'd5);
    req = 4'b0001;
    y_ready = 1'b1;
    wait_gnt("gnt_first", 4'b0001);
    exp_q.push_back(8);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("valid_in_add", y_valid, 0);
    @(negedge clk);
    chk("valid_in_hold", y_valid, 1);
    chk("first_y_out", y_out, 8);
    chk("first_y_id", y_id, 0);
    @(negedge clk);
    chk("first_count", op_count, 1);

    // boundaries: max operands and zero operands
    do_op(2, 4'd15, 4'd15, 30, "gnt_max");
    do_op(1, 4'd0, 4'd0, 0, "gnt_zero");

    // reset while requester 1 is in flight, then round-robin order with all requesting
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", y_valid, 0);
    set_ops(0, 4'd1, 4'd2);
    set_ops(1, 4'd6, 4'd7);
    set_ops(2, 4'd11, 4'd12);
    set_ops(3, 4'd15, 4'd15);
    @(posedge clk); #1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr_order", N'(1) << order[k]);
      exp_q.push_back(order[k] * 256 + sums[order[k]]);
      @(posedge clk); #1;
    end
    req = '0;
    drain();

    // consumer stalls five cycles while inputs churn
    @(posedge clk); #1;
    y_ready = 1'b0;
    do_op(3, 4'd9, 4'd4, 13, "gnt_hold");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      a_in = (N*W)'($urandom);
      b_in = (N*W)'($urandom);
      req  = 4'b1111;
      @(negedge clk);
      chk("stall_gnt", gnt, 0);
      chk("stall_valid", y_valid, 1);
      chk("stall_y_out", y_out, 13);
      chk("stall_y_id", y_id, 3);
    end
    @(posedge clk); #1;
    set_ops(0, 4'd7, 4'd8);
    y_ready = 1'b1;
    wait_gnt("gnt_after_hold", 4'b0001);
    exp_q.push_back(15);
    @(posedge clk); #1;
    req = '0;
    drain();

    // reset during ADD: pointer returns to 0
    @(posedge clk); #1;
    req = 4'b1111;
    wait_gnt("gnt_pre_rst", 4'b0010);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("gnt_in_rst", gnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_add_valid", y_valid, 0);
    chk("rst_add_count", op_count, 0);
    chk("gnt_post_rst", gnt, 4'b0001);
    exp_q.push_back(15);
    @(posedge clk); #1;
    req = '0;

    // random ops; after 256 accepted since reset the counter wraps to 0
    for (int i = 0; i < 255; i++) begin
      rid = int'($urandom_range(N - 1, 0));
      ra  = W'($urandom);
      rb  = W'($urandom);
      do_op(rid, ra, rb, int'(ra) + int'(rb), "gnt_rand");
    end
    drain();
    @(negedge clk);
    chk("count_wrap", op_count, 0);
    for (int i = 0; i < 745; i++) begin
      rid = int'($urandom_range(N - 1, 0));
      ra  = W'($urandom);
      rb  = W'($urandom);
      do_op(rid, ra, rb, int'(ra) + int'(rb), "gnt_rand");
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
